conv_layer_engine: RTL and testbench

Parametrised successor to the fixed 8x8 / 3x3 / 6-lane convolution top. It accepts a streamed weight set and image over a valid/ready handshake. It buffers KERNEL_SIZE image rows in a sliding row buffer, runs an ARRAY_SIZE-lane multiply-accumulate over the KxK window, and emits one complete output row per pass on a valid/ready output bus. It sits between the pixel source (ROM/DMA) and the pooling/next-layer stage.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_mac_lane.sv | 38 +++
 rtl/conv_layer_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_conv_layer_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine.
// Holds the FSM state encoding and a ceiling-log2 helper used to size
// counters and the output row index.
package conv_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_W    = 3'd1;
    localparam logic [2:0] ST_LOAD_ROWS = 3'd2;
    localparam logic [2:0] ST_CALC      = 3'd3;
    localparam logic [2:0] ST_OUT       = 3'd4;
    localparam logic [2:0] ST_LOAD_NEXT = 3'd5;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Counter width: never narrower than one bit.
    function automatic int cnt_w(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output lane of the convolution array.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the accumulator (takes priority over enable)
//   enable     : add pixel*weight into the accumulator this cycle
//   pixel      : window pixel for this lane
//   weight     : current kernel tap
//   acc        : accumulated result, wraps mod 2^WIDTH
module conv_mac_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] pixel,
    input  logic [WIDTH-1:0] weight,
    output logic [WIDTH-1:0] acc
);

    // Product kept to the low WIDTH bits; the multiply is evaluated in a
    // WIDTH-bit context so the upper half is never formed.
    function automatic logic [WIDTH-1:0] mul_trunc(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return a * b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + mul_trunc(pixel, weight);
        end
    end

endmodule

// File: rtl/conv_layer_engine.sv
// Streaming KxK convolution engine.
// Loads a KxK weight set (optionally reused from the previous frame), keeps
// K image rows in a sliding register buffer, and computes one output row of
// ARRAY_SIZE lanes per pass, one kernel tap per cycle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse to begin a frame while idle
//   weight_reuse    : sampled with start; skip weight load if weights valid
//   in_data/valid   : weight or pixel beat; in_ready accepts it
//   out_bus/valid   : completed output row (lane 0 in the low bits)
//   out_ready       : downstream accepts out_bus
//   out_row         : index of the row on out_bus
//   busy            : engine not idle
//   done            : one-cycle pulse after the final row is accepted
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int ARRAY_SIZE  = 6,
    localparam int ROW_W      = cnt_w(ARRAY_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        weight_reuse,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ARRAY_SIZE*WIDTH-1:0] out_bus,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROW_W-1:0]            out_row,
    output logic                        busy,
    output logic                        done
);

    localparam int KW = cnt_w(KERNEL_SIZE);
    localparam int CW = cnt_w(IMAGE_SIZE);
    localparam logic [KW-1:0]    K_LAST = KW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0]    N_LAST = CW'(IMAGE_SIZE - 1);
    localparam logic [ROW_W-1:0] A_LAST = ROW_W'(ARRAY_SIZE - 1);

    if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_bad_cfg
        $error("conv_layer_engine: ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
    end

    logic [2:0]       state;
    logic [KW-1:0]    kr;         // tap row; also weight-load row
    logic [KW-1:0]    kc;         // tap column; also weight-load column
    logic [KW-1:0]    prow;       // pixel row during initial row load
    logic [CW-1:0]    pcol;       // pixel column during any row load
    logic             weights_valid;

    logic [WIDTH-1:0] wgt     [KERNEL_SIZE][KERNEL_SIZE];
    logic [WIDTH-1:0] row_buf [KERNEL_SIZE][IMAGE_SIZE];
    logic [WIDTH-1:0] tap_row [IMAGE_SIZE];
    logic [WIDTH-1:0] lane_pix[ARRAY_SIZE];
    logic [WIDTH-1:0] tap_w;

    logic accept;
    logic mac_clear;
    logic mac_en;
    logic shift_rows;

    assign in_ready = (state == ST_LOAD_W) || (state == ST_LOAD_ROWS) ||
                      (state == ST_LOAD_NEXT);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;

    // Accumulators are zeroed on the last load beat so CALC starts clean.
    assign mac_clear = accept &&
                       (((state == ST_LOAD_ROWS) && (prow == K_LAST) && (pcol == N_LAST)) ||
                        ((state == ST_LOAD_NEXT) && (pcol == N_LAST)));
    assign mac_en     = (state == ST_CALC);
    assign shift_rows = (state == ST_OUT) && out_ready && (out_row != A_LAST);

    // Control: FSM and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            kr            <= '0;
            kc            <= '0;
            prow          <= '0;
            pcol          <= '0;
            weights_valid <= 1'b0;
            out_valid     <= 1'b0;
            out_row       <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        kr    <= '0;
                        kc    <= '0;
                        prow  <= '0;
                        pcol  <= '0;
                        state <= (weight_reuse && weights_valid) ? ST_LOAD_ROWS : ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (accept) begin
                        if (kc == K_LAST) begin
                            kc <= '0;
                            if (kr == K_LAST) begin
                                kr            <= '0;
                                weights_valid <= 1'b1;
                                state         <= ST_LOAD_ROWS;
                            end else begin
                                kr <= kr + 1'b1;
                            end
                        end else begin
                            kc <= kc + 1'b1;
                        end
                    end
                end
                ST_LOAD_ROWS: begin
                    if (accept) begin
                        if (pcol == N_LAST) begin
                            pcol <= '0;
                            if (prow == K_LAST) begin
                                prow  <= '0;
                                state <= ST_CALC;
                            end else begin
                                prow <= prow + 1'b1;
                            end
                        end else begin
                            pcol <= pcol + 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (kc == K_LAST) begin
                        kc <= '0;
                        if (kr == K_LAST) begin
                            kr        <= '0;
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            kr <= kr + 1'b1;
                        end
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_row == A_LAST) begin
                            out_row <= '0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            out_row <= out_row + 1'b1;
                            state   <= ST_LOAD_NEXT;
                        end
                    end
                end
                ST_LOAD_NEXT: begin
                    if (accept) begin
                        if (pcol == N_LAST) begin
                            pcol  <= '0;
                            state <= ST_CALC;
                        end else begin
                            pcol <= pcol + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage: weights and row buffer (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept && (state == ST_LOAD_W)) begin
            wgt[kr][kc] <= in_data;
        end
        if (shift_rows) begin
            for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
                for (int c = 0; c < IMAGE_SIZE; c++) begin
                    row_buf[r][c] <= row_buf[r+1][c];
                end
            end
        end
        if (accept && (state == ST_LOAD_ROWS)) begin
            row_buf[prow][pcol] <= in_data;
        end
        if (accept && (state == ST_LOAD_NEXT)) begin
            row_buf[KERNEL_SIZE-1][pcol] <= in_data;
        end
    end

    // Window select: lane i sees column i+kc of buffer row kr
    always_comb begin
        tap_row = row_buf[kr];
        tap_w   = wgt[kr][kc];
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lane_pix[i] = '0;
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                if (kc == KW'(c)) lane_pix[i] = tap_row[i+c];
            end
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        conv_mac_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (mac_clear),
            .enable (mac_en),
            .pixel  (lane_pix[i]),
            .weight (tap_w),
            .acc    (out_bus[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed, scoreboard-based bench for conv_layer_engine (default parameters).
module tb_conv_layer_engine;

    localparam int W  = 32;
    localparam int K  = 3;
    localparam int N  = 8;
    localparam int A  = 6;
    localparam int BW = A * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          weight_reuse = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] out_bus;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2:0]    out_row;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  wt [K][K];
    bit            wv = 1'b0;
    logic [BW-1:0] sb [$];

    conv_layer_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .weight_reuse (weight_reuse),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_bus      (out_bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pix(input int r, input int c);
        return W'(8 * r + c);
    endfunction

    function automatic logic [BW-1:0] exp_row(input int r);
        logic [BW-1:0] row;
        logic [W-1:0]  s;
        row = '0;
        for (int c = 0; c < A; c++) begin
            s = '0;
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    s = s + pix(r + kr, c + kc) * wt[kr][kc];
            row[c*W +: W] = s;
        end
        return row;
    endfunction

    // Called at a negedge; returns at a negedge after the beat transferred.
    task automatic push_beat(input logic [W-1:0] d, input bit gap);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", BW'(t < 50), BW'(1));
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic set_weights(input bit centre_only);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                wt[r][c] = centre_only ? W'((r == 1 && c == 1) ? 1 : 0) : W'(1);
    endtask

    task automatic run_frame(input bit reuse, input bit gap, input bit noise,
                             input int stall_row, input int abort_row);
        int t;
        logic [BW-1:0] held;
        logic [BW-1:0] expv;
        start        = 1'b1;
        weight_reuse = reuse;
        @(negedge clk);
        start        = 1'b0;
        weight_reuse = 1'b0;
        check("busy_after_start", BW'(busy), BW'(1));
        for (int r = 0; r < A; r++) sb.push_back(exp_row(r));
        if (!(reuse && wv)) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    push_beat(wt[r][c], gap);
            wv = 1'b1;
        end
        for (int r = 0; r < K; r++)
            for (int c = 0; c < N; c++)
                push_beat(pix(r, c), gap);
        for (int r = 0; r < A; r++) begin
            if (r == abort_row) begin
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("rst_out_valid", BW'(out_valid), BW'(0));
                check("rst_out_bus", out_bus, '0);
                check("rst_out_row", BW'(out_row), BW'(0));
                check("rst_busy", BW'(busy), BW'(0));
                check("rst_in_ready", BW'(in_ready), BW'(0));
                check("rst_done", BW'(done), BW'(0));
                @(negedge clk);
                rst_n = 1'b1;
                sb.delete();
                wv = 1'b0;
                return;
            end
            if (r == stall_row) out_ready = 1'b0;
            t = 0;
            while (out_valid !== 1'b1 && t < 200) begin
                if (noise) begin
                    in_valid = 1'b1;
                    in_data  = $urandom;
                    start    = (t % 2 == 0);
                end
                @(negedge clk);
                t++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            check("out_valid_wait", BW'(t < 200), BW'(1));
            expv = (sb.size() > 0) ? sb.pop_front() : '0;
            check($sformatf("row%0d_bus", r), out_bus, expv);
            check($sformatf("row%0d_idx", r), BW'(out_row), BW'(r));
            if (r == stall_row) begin
                held = out_bus;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", BW'(out_valid), BW'(1));
                    check("stall_bus", out_bus, held);
                    check("stall_row", BW'(out_row), BW'(r));
                    check("stall_in_ready", BW'(in_ready), BW'(0));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (r == A - 1) begin
                check("done_pulse", BW'(done), BW'(1));
                check("busy_fall", BW'(busy), BW'(0));
                check("valid_fall", BW'(out_valid), BW'(0));
                check("row_wrap", BW'(out_row), BW'(0));
                @(negedge clk);
                check("done_single", BW'(done), BW'(0));
            end else begin
                check("valid_drop", BW'(out_valid), BW'(0));
                for (int c = 0; c < N; c++) push_beat(pix(r + K, c), gap);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_out_valid", BW'(out_valid), BW'(0));
        check("reset_in_ready", BW'(in_ready), BW'(0));
        check("reset_busy", BW'(busy), BW'(0));
        check("reset_done", BW'(done), BW'(0));
        check("reset_out_bus", out_bus, '0);
        check("reset_out_row", BW'(out_row), BW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // all-ones kernel, plain frame
        set_weights(1'b0);
        run_frame(1'b0, 1'b0, 1'b0, -1, -1);
        // weight reuse with an output stall on row 2
        run_frame(1'b1, 1'b0, 1'b0, 2, -1);
        // centre-only kernel
        set_weights(1'b1);
        run_frame(1'b0, 1'b0, 1'b0, -1, -1);
        // all-ones again with gapped input and stray beats/starts
        set_weights(1'b0);
        run_frame(1'b0, 1'b1, 1'b1, -1, -1);
        // reset in the middle of row 3's computation
        run_frame(1'b1, 1'b0, 1'b0, -1, 3);
        @(negedge clk);
        // reuse requested but weights were cleared: full weight load
        run_frame(1'b1, 1'b0, 1'b0, -1, -1);

        check("scoreboard_empty", BW'(sb.size()), BW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
